serial_io_marine_radar: RTL and testbench

//  Host-side front end of the settings bus. Decodes the FX2 3-wire serial port (SEN/SCLK/SDI/SDO),

---
 rtl/serial_io_marine_radar.sv | 277 +++++++++++++++++++++++++++
 tb/tb_serial_io_marine_radar.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_io_marine_radar.sv
// serial_io_marine_radar
// Host-side front end of the settings bus. Decodes the FX2 3-wire serial port
// (SEN/SCLK/SDI/SDO), oversampled in master_clk, into serial_addr/serial_data/
// serial_strobe for the setting registers, and serves 32-bit readback on SDO.
//
// Frame: SEN low, 40 SCLK rising edges: R/W (1=read), 7 address bits MSB first,
// 32 data bits MSB first. The host samples SDO on SCLK rising.
//
// Optional feature: define SERIAL_IO_TIMEOUT_EN to abort a frame after
// TIMEOUT_CYCLES master_clk cycles without any SCLK edge while SEN is low.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no frame in progress, waiting for a SEN falling edge
// S_ADDR  | collecting the R/W bit and the 7 address bits
// S_WDATA | write frame, collecting the 32 data bits
// S_RDATA | read frame, readback data being shifted out on sdo
// S_ABORT | frame abandoned after a timeout, waiting for SEN to rise

module serial_io_marine_radar #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        master_clk,
  input  logic        reset_n,
  input  logic        sen_n,
  input  logic        sclk,
  input  logic        sdi,
  output logic        sdo,
  output logic        sdo_oe,
  output logic [6:0]  serial_addr,
  output logic [31:0] serial_data,
  output logic        serial_strobe,
  output logic [6:0]  readback_addr,
  output logic        readback_req,
  input  logic [31:0] readback_data,
  output logic        xfer_error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_RDATA = 3'd3,
    S_ABORT = 3'd4
  } state_t;

  localparam logic [5:0] CNT_ADDR_LAST = 6'd7;
  localparam logic [5:0] CNT_DATA_LAST = 6'd39;
  localparam logic [5:0] CNT_FRAME     = 6'd40;
  localparam logic [5:0] CNT_SAT       = 6'd41;

  // Parameter sanity checks at elaboration
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("serial_io_marine_radar: SYNC_STAGES must be at least 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("serial_io_marine_radar: TIMEOUT_CYCLES must be at least 2");
  end

  // Synchronizer chains and edge-detect flops
  logic [SYNC_STAGES-1:0] sen_sync_q;
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] sdi_sync_q;
  logic                   sen_last_q;
  logic                   sclk_last_q;

  logic sen_s;
  logic sclk_s;
  logic sdi_s;
  logic sen_fall;
  logic sen_rise;
  logic sclk_rise;
  logic sclk_fall;

  // FSM and frame capture
  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        rw_q, rw_d;
  logic [6:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        commit_q, commit_d;
  logic        err_pend_q, err_pend_d;
  logic        active;
  logic        bit_take;
  logic        go_rd;
  logic        tmo_hit;

  // Committed outputs
  logic [6:0]  serial_addr_q;
  logic [31:0] serial_data_q;
  logic        serial_strobe_q;
  logic        xfer_error_q;

  // Readback path
  logic [6:0]  readback_addr_q, readback_addr_d;
  logic        readback_req_q;
  logic        ld_q;
  logic [31:0] shreg_q, shreg_d;
  logic        skip_q, skip_d;
  logic        oe_q, oe_d;

  assign sen_s     = sen_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
  assign sen_fall  = !sen_s && sen_last_q;
  assign sen_rise  = sen_s && !sen_last_q;
  assign sclk_rise = sclk_s && !sclk_last_q;
  assign sclk_fall = !sclk_s && sclk_last_q;

  assign active   = (state_q == S_ADDR) || (state_q == S_WDATA) || (state_q == S_RDATA);
  assign bit_take = active && !sen_s && sclk_rise;
  assign go_rd    = (state_q == S_ADDR) && (state_d == S_RDATA);

  // Synchronize the pins; left unreset so that a SEN already low at reset
  // release does not look like a new falling edge (the frame is dropped instead)
  always_ff @(posedge master_clk) begin
    sen_sync_q  <= {sen_sync_q[SYNC_STAGES-2:0], sen_n};
    sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
    sen_last_q  <= sen_s;
    sclk_last_q <= sclk_s;
  end

`ifdef SERIAL_IO_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_q;

  // Inactivity timer: runs only inside a frame, restarts on every SCLK edge
  always_ff @(posedge master_clk) begin
    if (!reset_n || sen_fall || sclk_rise || sclk_fall || !active || sen_s) begin
      tmo_q <= '0;
    end else if (tmo_q != TMO_MAX) begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  assign tmo_hit = active && !sen_s && !sclk_rise && !sclk_fall && (tmo_q == TMO_MAX);
`else
  assign tmo_hit = 1'b0;
`endif

  // Next state plus the commit/error decision taken on the SEN rising edge
  always_comb begin
    state_d    = state_q;
    commit_d   = 1'b0;
    err_pend_d = 1'b0;
    if (sen_fall) begin
      state_d = S_ADDR;
    end else if (sen_rise) begin
      state_d = S_IDLE;
      if (state_q == S_WDATA && cnt_q == CNT_FRAME) begin
        commit_d = 1'b1;
      end else if (active && cnt_q != 6'd0 &&
                   !(state_q == S_RDATA && cnt_q == CNT_FRAME)) begin
        err_pend_d = 1'b1;
      end
    end else if (tmo_hit) begin
      state_d    = S_ABORT;
      err_pend_d = 1'b1;
    end else if (state_q == S_ADDR && bit_take && cnt_q == CNT_ADDR_LAST) begin
      state_d = rw_q ? S_RDATA : S_WDATA;
    end
  end

  // Bit counter and frame capture (R/W, address, write data)
  always_comb begin
    cnt_d  = cnt_q;
    rw_d   = rw_q;
    addr_d = addr_q;
    data_d = data_q;
    if (sen_fall) begin
      cnt_d = 6'd0;
    end else if (bit_take) begin
      if (cnt_q != CNT_SAT) begin
        cnt_d = cnt_q + 6'd1;
      end
      if (cnt_q == 6'd0) begin
        rw_d = sdi_s;
      end else if (cnt_q <= CNT_ADDR_LAST) begin
        addr_d = {addr_q[5:0], sdi_s};
      end else if (cnt_q <= CNT_DATA_LAST) begin
        data_d = {data_q[30:0], sdi_s};
      end
    end
  end

  // Readback shifter: load two cycles after the request, skip the first SCLK
  // fall after the address, then shift left once per fall
  always_comb begin
    readback_addr_d = readback_addr_q;
    shreg_d         = shreg_q;
    skip_d          = skip_q;
    oe_d            = 1'b0;
    if (go_rd) begin
      readback_addr_d = {addr_q[5:0], sdi_s};
      skip_d          = 1'b1;
    end
    if (state_q == S_RDATA && state_d == S_RDATA) begin
      oe_d = oe_q || ld_q;
      if (ld_q) begin
        shreg_d = readback_data;
      end else if (sclk_fall) begin
        if (skip_q) begin
          skip_d = 1'b0;
        end else begin
          shreg_d = {shreg_q[30:0], 1'b0};
        end
      end
      if (ld_q && sclk_fall && skip_q) begin
        skip_d = 1'b0;
      end
    end
  end

  // State, frame and readback registers
  always_ff @(posedge master_clk) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      cnt_q           <= 6'd0;
      rw_q            <= 1'b0;
      addr_q          <= 7'd0;
      data_q          <= 32'd0;
      commit_q        <= 1'b0;
      err_pend_q      <= 1'b0;
      readback_addr_q <= 7'd0;
      readback_req_q  <= 1'b0;
      ld_q            <= 1'b0;
      shreg_q         <= 32'd0;
      skip_q          <= 1'b0;
      oe_q            <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      rw_q            <= rw_d;
      addr_q          <= addr_d;
      data_q          <= data_d;
      commit_q        <= commit_d;
      err_pend_q      <= err_pend_d;
      readback_addr_q <= readback_addr_d;
      readback_req_q  <= go_rd;
      ld_q            <= readback_req_q;
      shreg_q         <= shreg_d;
      skip_q          <= skip_d;
      oe_q            <= oe_d;
    end
  end

  // Write commit one cycle after the decision; outputs hold until the next write
  always_ff @(posedge master_clk) begin
    if (!reset_n) begin
      serial_addr_q   <= 7'd0;
      serial_data_q   <= 32'd0;
      serial_strobe_q <= 1'b0;
      xfer_error_q    <= 1'b0;
    end else begin
      serial_strobe_q <= commit_q;
      xfer_error_q    <= err_pend_q;
      if (commit_q) begin
        serial_addr_q <= addr_q;
        serial_data_q <= data_q;
      end
    end
  end

  assign serial_addr   = serial_addr_q;
  assign serial_data   = serial_data_q;
  assign serial_strobe = serial_strobe_q;
  assign xfer_error    = xfer_error_q;
  assign readback_addr = readback_addr_q;
  assign readback_req  = readback_req_q;
  assign sdo_oe        = oe_q && !sen_rise;
  assign sdo           = sdo_oe && shreg_q[31];

endmodule

// File: tb/tb_serial_io_marine_radar.sv
// Self-checking bench for serial_io_marine_radar: table of write frames plus
// hand-written read, reset-mid-frame and stalled-SCLK sequences.

module tb_serial_io_marine_radar;

  localparam int SYNC = 2;

  logic        master_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sen_n = 1'b1;
  logic        sclk = 1'b1;
  logic        sdi = 1'b0;
  logic        sdo;
  logic        sdo_oe;
  logic [6:0]  serial_addr;
  logic [31:0] serial_data;
  logic        serial_strobe;
  logic [6:0]  readback_addr;
  logic        readback_req;
  logic [31:0] readback_data = 32'h0;
  logic        xfer_error;

  always #5 master_clk = ~master_clk;

  serial_io_marine_radar #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(64)) dut (
    .master_clk    (master_clk),
    .reset_n       (reset_n),
    .sen_n         (sen_n),
    .sclk          (sclk),
    .sdi           (sdi),
    .sdo           (sdo),
    .sdo_oe        (sdo_oe),
    .serial_addr   (serial_addr),
    .serial_data   (serial_data),
    .serial_strobe (serial_strobe),
    .readback_addr (readback_addr),
    .readback_req  (readback_req),
    .readback_data (readback_data),
    .xfer_error    (xfer_error)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_strobe = 0;
  int n_err = 0;
  int n_req = 0;
  int strobe_cyc = -1;
  int rise_cyc = 0;

  always @(posedge master_clk) cyc <= cyc + 1;

  // Event counters, sampled on the falling edge
  always @(negedge master_clk) begin
    if (serial_strobe) begin
      n_strobe   <= n_strobe + 1;
      strobe_cyc <= cyc;
    end
    if (xfer_error) n_err <= n_err + 1;
    if (readback_req) n_req <= n_req + 1;
  end

  // Register-file model: data valid the cycle after the request, then garbage
  always @(posedge master_clk) begin
    if (readback_req)
      readback_data <= (readback_addr == 7'h21) ? 32'h12345678 : 32'hBAD0BAD0;
    else
      readback_data <= 32'h0;
  end

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge master_clk);
  endtask

  // One SCLK period (8 master clocks); host samples sdo just as SCLK rises
  task automatic sbit(input logic b, output logic s, output logic oe);
    sdi  = b;
    sclk = 1'b0;
    tick(4);
    s    = sdo;
    oe   = sdo_oe;
    sclk = 1'b1;
    tick(4);
  endtask

  task automatic frame(input logic [39:0] f, input int nbits,
                       output logic [31:0] rd, output logic oe9);
    logic s, oe;
    rd  = '0;
    oe9 = 1'b0;
    sen_n = 1'b0;
    tick(4);
    for (int i = 0; i < nbits; i++) begin
      sbit((i < 40) ? f[39 - i] : 1'b0, s, oe);
      if (i >= 8 && i < 40) rd = {rd[30:0], s};
      if (i == 8) oe9 = oe;
    end
    tick(4);
    sen_n    = 1'b1;
    rise_cyc = cyc;
  endtask

  typedef struct {
    logic        rw;
    logic [6:0]  addr;
    logic [31:0] data;
    int          nbits;
    int          gap;
    int          exp_strobe;
    int          exp_err;
    logic [6:0]  exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [31:0] rd;
    logic        oe9, s, oe;
    int          s0, e0, r0;
    logic [39:0] f;

    vecs[0] = '{1'b0, 7'h05, 32'hDEADBEEF, 40, 8, 1, 0, 7'h05, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 7'h33, 32'h11111111, 39, 8, 0, 1, 7'h05, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 7'h33, 32'h11111111, 41, 8, 0, 1, 7'h05, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 7'h33, 32'h11111111,  0, 8, 0, 0, 7'h05, 32'hDEADBEEF};
    vecs[4] = '{1'b0, 7'h01, 32'h00000001, 40, 4, 1, 0, 7'h01, 32'h00000001};
    vecs[5] = '{1'b0, 7'h02, 32'hFFFFFFFF, 40, 8, 1, 0, 7'h02, 32'hFFFFFFFF};
    vecs[6] = '{1'b0, 7'h44, 32'h12345678,  8, 8, 0, 1, 7'h02, 32'hFFFFFFFF};

    // Reset state
    tick(3);
    #1;
    check("rst_addr_data", {serial_addr, serial_data}, 0);
    check("rst_ctrl", {serial_strobe, readback_addr, readback_req, sdo, sdo_oe, xfer_error}, 0);
    reset_n = 1'b1;
    tick(4);

    // Table-driven write frames
    for (int i = 0; i < 7; i++) begin
      s0 = n_strobe;
      e0 = n_err;
      frame({vecs[i].rw, vecs[i].addr, vecs[i].data}, vecs[i].nbits, rd, oe9);
      tick(vecs[i].gap);
      #1;
      check($sformatf("v%0d_strobes", i), n_strobe - s0, vecs[i].exp_strobe);
      check($sformatf("v%0d_errors", i), n_err - e0, vecs[i].exp_err);
      check($sformatf("v%0d_addr", i), serial_addr, vecs[i].exp_addr);
      check($sformatf("v%0d_data", i), serial_data, vecs[i].exp_data);
      if (vecs[i].exp_strobe == 1)
        check($sformatf("v%0d_latency", i), strobe_cyc - rise_cyc, SYNC + 2);
    end

    // Read of address 0x21
    s0 = n_strobe; e0 = n_err; r0 = n_req;
    frame({1'b1, 7'h21, 32'h0}, 40, rd, oe9);
    tick(8);
    #1;
    check("rd_data", rd, 32'h12345678);
    check("rd_oe_during", oe9, 1);
    check("rd_req_count", n_req - r0, 1);
    check("rd_addr", readback_addr, 7'h21);
    check("rd_oe_after", sdo_oe, 0);
    check("rd_sdo_after", sdo, 0);
    check("rd_no_strobe", n_strobe - s0, 0);
    check("rd_no_error", n_err - e0, 0);

    // Reset at bit 20 of a write, then a full write
    s0 = n_strobe; e0 = n_err;
    f = {1'b0, 7'h55, 32'hCAFEF00D};
    sen_n = 1'b0;
    tick(4);
    for (int i = 0; i < 20; i++) sbit(f[39 - i], s, oe);
    reset_n = 1'b0;
    tick(2);
    #1;
    check("midrst_addr_data", {serial_addr, serial_data}, 0);
    check("midrst_ctrl", {serial_strobe, readback_addr, readback_req, sdo, sdo_oe, xfer_error}, 0);
    tick(2);
    reset_n = 1'b1;
    for (int i = 20; i < 40; i++) sbit(f[39 - i], s, oe);
    tick(4);
    sen_n = 1'b1;
    tick(8);
    #1;
    check("midrst_no_strobe", n_strobe - s0, 0);
    check("midrst_no_error", n_err - e0, 0);
    s0 = n_strobe;
    frame({1'b0, 7'h7F, 32'hA5A5A5A5}, 40, rd, oe9);
    tick(8);
    #1;
    check("postrst_strobes", n_strobe - s0, 1);
    check("postrst_addr", serial_addr, 7'h7F);
    check("postrst_data", serial_data, 32'hA5A5A5A5);

    // SCLK stalls for 100 cycles after bit 12
    s0 = n_strobe; e0 = n_err;
    f = {1'b0, 7'h11, 32'h0F0F0F0F};
    sen_n = 1'b0;
    tick(4);
    for (int i = 0; i < 12; i++) sbit(f[39 - i], s, oe);
    tick(100);
    #1;
`ifdef SERIAL_IO_TIMEOUT_EN
    check("stall_error", n_err - e0, 1);
    check("stall_oe", sdo_oe, 0);
`else
    check("stall_error", n_err - e0, 0);
`endif
    for (int i = 12; i < 40; i++) sbit(f[39 - i], s, oe);
    tick(4);
    sen_n = 1'b1;
    tick(8);
    #1;
`ifdef SERIAL_IO_TIMEOUT_EN
    check("stall_strobes", n_strobe - s0, 0);
    check("stall_total_err", n_err - e0, 1);
    check("stall_data", serial_data, 32'hA5A5A5A5);
`else
    check("stall_strobes", n_strobe - s0, 1);
    check("stall_total_err", n_err - e0, 0);
    check("stall_addr", serial_addr, 7'h11);
    check("stall_data", serial_data, 32'h0F0F0F0F);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
